soc_system_pio_master: RTL and testbench

//  Avalon-MM initiator that drives the SoC's PIO-style slaves (32-bit data, chipselect/write_n/read_n).

---
 rtl/soc_system_avm_pkg.sv | 15 +
 rtl/soc_system_pio_master.sv | 172 +++++++++++++++++
 tb/tb_soc_system_pio_master.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_system_avm_pkg.sv
// Shared types for the SoC Avalon-MM PIO initiator.
// Transfer FSM states and the fixed bus data width.
package soc_system_avm_pkg;

    localparam int unsigned AVM_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RDWAIT,
        RESP
    } pio_state_t;

endpackage

// File: rtl/soc_system_pio_master.sv
// Single-beat Avalon-MM initiator for PIO-style slaves.
// One outstanding command, registered bus strobes, stall timeout.
module soc_system_pio_master
    import soc_system_avm_pkg::*;
#(
    parameter int unsigned ADDR_W         = 2,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_address,
    input  logic [AVM_DATA_W-1:0] cmd_writedata,
    output logic                  rsp_valid,
    output logic [AVM_DATA_W-1:0] rsp_readdata,
    output logic                  rsp_timeout,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_chipselect,
    output logic                  avm_write_n,
    output logic                  avm_read_n,
    output logic [AVM_DATA_W-1:0] avm_writedata,
    input  logic [AVM_DATA_W-1:0] avm_readdata,
    input  logic                  avm_waitrequest
);

    // A zero timeout still needs a one-bit counter to keep widths legal.
    localparam int unsigned CNT_W =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [1:0] LAT_LAST =
        (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

    if (READ_LATENCY > 3) begin : g_bad_latency
        $error("soc_system_pio_master: READ_LATENCY must be 0..3");
    end

    pio_state_t            state_q, state_d;
    logic [CNT_W-1:0]      to_cnt_q, to_cnt_d;
    logic [1:0]            lat_cnt_q, lat_cnt_d;
    logic                  cmd_ready_d;
    logic                  rsp_valid_d;
    logic [AVM_DATA_W-1:0] rsp_readdata_d;
    logic                  rsp_timeout_d;
    logic [ADDR_W-1:0]     avm_address_d;
    logic                  avm_chipselect_d;
    logic                  avm_write_n_d;
    logic                  avm_read_n_d;
    logic [AVM_DATA_W-1:0] avm_writedata_d;
    logic                  to_hit;

    // Abort when this stall cycle would be the TIMEOUT_CYCLES-th in a row.
    always_comb begin
        to_hit = (TIMEOUT_CYCLES != 0) &&
                 ((32'(to_cnt_q) + 32'd1) >= TIMEOUT_CYCLES);
    end

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        state_d          = state_q;
        to_cnt_d         = to_cnt_q;
        lat_cnt_d        = lat_cnt_q;
        cmd_ready_d      = cmd_ready;
        rsp_valid_d      = 1'b0;
        rsp_readdata_d   = rsp_readdata;
        rsp_timeout_d    = rsp_timeout;
        avm_address_d    = avm_address;
        avm_chipselect_d = avm_chipselect;
        avm_write_n_d    = avm_write_n;
        avm_read_n_d     = avm_read_n;
        avm_writedata_d  = avm_writedata;

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid) begin
                    state_d          = cmd_write ? WRITE : READ;
                    cmd_ready_d      = 1'b0;
                    to_cnt_d         = '0;
                    avm_address_d    = cmd_address;
                    avm_writedata_d  = cmd_writedata;
                    avm_chipselect_d = 1'b1;
                    avm_write_n_d    = ~cmd_write;
                    avm_read_n_d     = cmd_write;
                end
            end

            WRITE, READ: begin
                if (!avm_waitrequest) begin
                    avm_chipselect_d = 1'b0;
                    avm_write_n_d    = 1'b1;
                    avm_read_n_d     = 1'b1;
                    if (state_q == WRITE || READ_LATENCY == 0) begin
                        state_d       = RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_timeout_d = 1'b0;
                        rsp_readdata_d =
                            (state_q == WRITE) ? '0 : avm_readdata;
                    end else begin
                        state_d   = RDWAIT;
                        lat_cnt_d = 2'd0;
                    end
                end else if (to_hit) begin
                    avm_chipselect_d = 1'b0;
                    avm_write_n_d    = 1'b1;
                    avm_read_n_d     = 1'b1;
                    state_d          = RESP;
                    rsp_valid_d      = 1'b1;
                    rsp_timeout_d    = 1'b1;
                    rsp_readdata_d   = '0;
                end else if (to_cnt_q != {CNT_W{1'b1}}) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            RDWAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d        = RESP;
                    rsp_valid_d    = 1'b1;
                    rsp_timeout_d  = 1'b0;
                    rsp_readdata_d = avm_readdata;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end

            RESP: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
            end

            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    // Register FSM state, counters and every output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            to_cnt_q       <= '0;
            lat_cnt_q      <= 2'd0;
            cmd_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_readdata   <= '0;
            rsp_timeout    <= 1'b0;
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_read_n     <= 1'b1;
            avm_writedata  <= '0;
        end else begin
            state_q        <= state_d;
            to_cnt_q       <= to_cnt_d;
            lat_cnt_q      <= lat_cnt_d;
            cmd_ready      <= cmd_ready_d;
            rsp_valid      <= rsp_valid_d;
            rsp_readdata   <= rsp_readdata_d;
            rsp_timeout    <= rsp_timeout_d;
            avm_address    <= avm_address_d;
            avm_chipselect <= avm_chipselect_d;
            avm_write_n    <= avm_write_n_d;
            avm_read_n     <= avm_read_n_d;
            avm_writedata  <= avm_writedata_d;
        end
    end

endmodule

// File: tb/tb_soc_system_pio_master.sv
// Bench for soc_system_pio_master: directed cases plus random
// transactions against a transaction-level memory/latency model.
module tb_soc_system_pio_master;

    localparam int AW = 2;
    localparam int RL = 1;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_address;
    logic [31:0]   cmd_writedata;
    logic          rsp_valid;
    logic [31:0]   rsp_readdata;
    logic          rsp_timeout;
    logic [AW-1:0] avm_address;
    logic          avm_chipselect;
    logic          avm_write_n;
    logic          avm_read_n;
    logic [31:0]   avm_writedata;
    logic [31:0]   avm_readdata;
    logic          avm_waitrequest;

    always #5 clk = ~clk;

    soc_system_pio_master #(
        .ADDR_W(AW),
        .READ_LATENCY(RL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_address(cmd_address),
        .cmd_writedata(cmd_writedata),
        .rsp_valid(rsp_valid),
        .rsp_readdata(rsp_readdata),
        .rsp_timeout(rsp_timeout),
        .avm_address(avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n),
        .avm_read_n(avm_read_n),
        .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0]   slv_mem [4];
    logic [31:0]   ref_mem [4];
    int            stall_left = 0;
    bit            rd_due = 1'b0;
    logic [31:0]   rd_val = '0;
    int            cyc = 0;
    int            nstrobe = 0;
    int            nwrites = 0;
    int            nrsp = 0;
    int            rsp_cyc = 0;
    int            both_bad = 0;
    int            ready_bad = 0;
    int            move_bad = 0;
    int            hold_bad = 0;
    bit            busy = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic [31:0]   cur_data = '0;
    bit            cur_wr = 1'b0;
    logic [31:0]   last_rd = '0;
    logic          last_to = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: slave bookkeeping before the edge, new slave drive after.
    task automatic cycle();
        bit            acc_wr;
        bit            acc_rd;
        bit            rst;
        bit            strobe;
        logic [AW-1:0] a;
        logic [31:0]   d;
        acc_wr = avm_chipselect && !avm_write_n && !avm_waitrequest;
        acc_rd = avm_chipselect && !avm_read_n && !avm_waitrequest;
        rst    = reset;
        a      = avm_address;
        d      = avm_writedata;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            acc_wr  = 1'b0;
            acc_rd  = 1'b0;
            last_rd = '0;
            last_to = 1'b0;
        end
        if (acc_wr) begin
            slv_mem[a] = d;
            nwrites++;
        end
        rd_due = acc_rd;
        if (acc_rd) rd_val = slv_mem[a];
        avm_readdata = rd_due ? rd_val : $urandom;
        strobe = avm_chipselect && (!avm_write_n || !avm_read_n);
        if (!avm_write_n && !avm_read_n) both_bad++;
        if (strobe) begin
            nstrobe++;
            if (avm_address !== cur_addr ||
                (cur_wr && avm_writedata !== cur_data)) move_bad++;
            if (stall_left > 0) begin
                avm_waitrequest = 1'b1;
                stall_left--;
            end else begin
                avm_waitrequest = 1'b0;
            end
        end else begin
            avm_waitrequest = 1'($urandom_range(0, 1));
        end
        if (busy && cmd_ready) ready_bad++;
        if (rsp_valid) begin
            nrsp++;
            last_rd = rsp_readdata;
            last_to = rsp_timeout;
            rsp_cyc = cyc;
            busy    = 1'b0;
        end else if (!rst && (rsp_readdata !== last_rd ||
                              rsp_timeout !== last_to)) begin
            hold_bad++;
        end
    endtask

    // Full command: handshake, response, and checks against the model.
    task automatic issue(input bit wr, input logic [AW-1:0] addr,
                         input logic [31:0] data, input int stall,
                         input string tag);
        int          t0;
        int          base_w;
        int          n0;
        int          exp_lat;
        int          exp_str;
        int          guard;
        bit          to;
        logic [31:0] exp_rd;
        to      = (stall >= TO);
        exp_lat = to ? TO + 1 : (wr ? 2 + stall : 2 + RL + stall);
        exp_str = to ? TO : stall + 1;
        cmd_write     = wr;
        cmd_address   = addr;
        cmd_writedata = data;
        cmd_valid     = 1'b1;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            cycle();
            guard++;
        end
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        cur_addr   = addr;
        cur_data   = data;
        cur_wr     = wr;
        stall_left = stall;
        nstrobe    = 0;
        base_w     = nwrites;
        n0         = nrsp;
        cycle();
        busy          = 1'b1;
        t0            = cyc;
        cmd_valid     = 1'b0;
        cmd_write     = 1'($urandom);
        cmd_address   = AW'($urandom);
        cmd_writedata = $urandom;
        guard = 0;
        while (nrsp == n0 && guard < 50) begin
            cycle();
            guard++;
        end
        stall_left = 0;
        busy       = 1'b0;
        if (wr && !to) ref_mem[addr] = data;
        exp_rd = (wr || to) ? 32'd0 : ref_mem[addr];
        check({tag, "_nrsp"}, 32'(nrsp - n0), 32'd1);
        check({tag, "_lat"}, 32'(rsp_cyc - t0 + 1), 32'(exp_lat));
        check({tag, "_rdata"}, last_rd, exp_rd);
        check({tag, "_tmo"}, 32'(last_to), 32'(to));
        check({tag, "_strobes"}, 32'(nstrobe), 32'(exp_str));
        check({tag, "_buswr"}, 32'(nwrites - base_w), 32'(wr && !to));
        cycle();
        check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
        check({tag, "_idle"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int hs [3];
        int n0;
        int base_w;
        int g;

        reset           = 1'b1;
        cmd_valid       = 1'b0;
        cmd_write       = 1'b0;
        cmd_address     = '0;
        cmd_writedata   = '0;
        avm_readdata    = '0;
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 4; i++) begin
            slv_mem[i] = $urandom;
            ref_mem[i] = slv_mem[i];
        end

        repeat (3) cycle();
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("rst_rsp_readdata", rsp_readdata, 32'd0);
        check("rst_cs", 32'(avm_chipselect), 32'd0);
        check("rst_write_n", 32'(avm_write_n), 32'd1);
        check("rst_read_n", 32'(avm_read_n), 32'd1);
        check("rst_address", 32'(avm_address), 32'd0);
        check("rst_writedata", avm_writedata, 32'd0);
        reset = 1'b0;
        cycle();

        issue(1'b1, 2'd0, 32'h0000_0001, 0, "t1_write");

        slv_mem[0] = 32'h0000_00A5;
        ref_mem[0] = 32'h0000_00A5;
        issue(1'b0, 2'd0, 32'h0, 0, "t2_read");

        issue(1'b1, 2'd2, 32'hCAFE_0003, 4, "t3_stall");

        issue(1'b0, 2'd1, 32'h0, 20, "t4_timeout");
        issue(1'b1, 2'd3, 32'h1234_5678, 8, "t4_wr_timeout");
        issue(1'b0, 2'd3, 32'h0, 7, "t4_edge_stall");

        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        base_w    = nwrites;
        n0        = nrsp;
        for (int k = 0; k < 3; k++) begin
            g = 0;
            while (!cmd_ready && g < 20) begin
                cycle();
                g++;
            end
            cmd_address   = AW'(k);
            cmd_writedata = 32'hB000_0000 + 32'(k);
            cur_addr      = AW'(k);
            cur_data      = cmd_writedata;
            cur_wr        = 1'b1;
            ref_mem[k]    = cmd_writedata;
            hs[k]         = cyc;
            cycle();
            busy = 1'b1;
            if (k == 2) cmd_valid = 1'b0;
        end
        g = 0;
        while (nrsp - n0 < 3 && g < 30) begin
            cycle();
            g++;
        end
        busy = 1'b0;
        repeat (3) cycle();
        check("t5_bus_writes", 32'(nwrites - base_w), 32'd3);
        check("t5_responses", 32'(nrsp - n0), 32'd3);
        check("t5_spacing", 32'(hs[2] - hs[0]), 32'd6);

        for (int k = 0; k < 3; k++)
            issue(1'b0, AW'(k), 32'h0, 0, "t5_readback");

        cmd_write   = 1'b0;
        cmd_address = 2'd1;
        cmd_valid   = 1'b1;
        g = 0;
        while (!cmd_ready && g < 20) begin
            cycle();
            g++;
        end
        cur_addr   = 2'd1;
        cur_wr     = 1'b0;
        stall_left = 1000;
        n0         = nrsp;
        cycle();
        cmd_valid = 1'b0;
        repeat (3) cycle();
        check("t6_stalled_read_n", 32'(avm_read_n), 32'd0);
        reset = 1'b1;
        cycle();
        reset      = 1'b0;
        stall_left = 0;
        check("t6_read_n", 32'(avm_read_n), 32'd1);
        check("t6_cs", 32'(avm_chipselect), 32'd0);
        check("t6_ready", 32'(cmd_ready), 32'd1);
        cycle();
        check("t6_no_rsp", 32'(nrsp - n0), 32'd0);
        issue(1'b0, 2'd1, 32'h0, 1, "t6_after");

        for (int n = 0; n < 40; n++) begin
            bit w;
            int r;
            int s;
            w = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            s = (r == 0) ? int'($urandom_range(TO, TO + 3))
                         : int'($urandom_range(0, 4));
            issue(w, AW'($urandom), $urandom, s, "rnd");
        end

        check("both_strobes", 32'(both_bad), 32'd0);
        check("ready_in_xfer", 32'(ready_bad), 32'd0);
        check("addr_data_move", 32'(move_bad), 32'd0);
        check("rsp_hold", 32'(hold_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
